imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate generator. Takes instruction fields plus a 32-bit two's-complement immediate and a format code, and packs them into RV32I instruction words.
- Used by the debug program buffer and the self-test instruction generator.
- Range-checks the immediate against the selected format.
- Optionally expands an out-of-range `li` (ADDI rd,x0,imm) into a LUI+ADDI pair.
- Output is registered and uses a valid/ready handshake.

Parameters:
EXPAND_LI  1  1: expand out-of-range li into LUI+ADDI; 0: flag it as an error

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  request valid
ready_o  output  1  request accepted when valid_i & ready_o
fmt_i  input  3  0=I, 1=S, 2=B, 3=U, 4=J; 5-7 reserved
opcode_i  input  7  opcode field
funct3_i  input  3  funct3 (I/S/B)
rd_i  input  5  rd (I/U/J)
rs1_i  input  5  rs1 (I/S/B)
rs2_i  input  5  rs2 (S/B)
imm_i  input  32  immediate value, sign-extended
instr_o  output  32  encoded instruction
instr_valid_o  output  1  instr_o valid
instr_ready_i  input  1  consumer accepts when instr_valid_o & instr_ready_i
last_o  output  1  final word of this request
err_o  output  1  request rejected; instr_o=0

Behaviour:
- Reset (async, rst_ni=0), all registered outputs clear:
  - state=IDLE
  - instr_valid_o=0, instr_o=0, last_o=0, err_o=0
  - held ADDI word cleared
- Reset mid-expansion discards the pending second word.
- States:
  - IDLE: output empty.
  - OUT1: first or only word held.
  - OUT2: ADDI of an expansion held.
- ready_o = (state==IDLE) | (instr_valid_o & instr_ready_i & last_o). Combinational on instr_ready_i. Allows back-to-back single-word requests at 1/cycle.
- Accept:
  - Encoded word registered; next cycle instr_valid_o=1 (latency 1).
  - state→OUT1.
- Field packing:
  - I: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Legality:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 5-7: always illegal.
- Expansion condition: EXPAND_LI=1, fmt=I, op=7'h13, f3=0, rs1=0, rd≠0, and imm outside I range. Then:
  - lo = sign-extended imm[11:0]; hi = (imm + 0x800) >> 12, 20-bit with wrap.
  - OUT1 presents LUI rd,hi (op 7'h37) with last_o=0.
  - ADDI rd,rd,lo is held internally.
- Illegal request, non-expandable:
  - Still accepted (one word).
  - instr_o=0, err_o=1, last_o=1, instr_valid_o=1.
  - err_o is valid only with instr_valid_o.
- Transitions:
  - OUT1 handshake & last_o:
    - new accept → OUT1 with new word;
    - else → IDLE, instr_valid_o=0.
  - OUT1 handshake & !last_o → OUT2: instr_o=ADDI word, last_o=1, err_o=0.
  - OUT2 handshake → as OUT1 with last_o.
- Back-pressure: while instr_valid_o & !instr_ready_i, instr_o, last_o and err_o hold stable and ready_o=0.
- valid_i while ready_o=0: ignored. The requester holds its request.

Test Plan:
- ADDI x5,x0,-1 (fmt0, op13, rd5, rs1 0, imm FFFFFFFF): instr_o=FFF00293, last=1, err=0, one cycle after accept.
- li x5,0x12345678 (EXPAND_LI=1): word1 123452B7 last=0; word2 67828293 last=1. With instr_ready_i held low 3 cycles between them, words stay stable and ready_o=0.
- BEQ x1,x2,-4 (fmt2, op63, imm FFFFFFFC) → FE208EE3. JAL x1,2048 (fmt4, op6F, rd1, imm 800) → 001000EF.
- B imm=3, U imm=0x1001, S imm=2048, and fmt=6: each gives instr_o=0, err=1, last=1. With EXPAND_LI=0, li 0x12345678 → err=1.
- Stream 4 legal I-type requests with instr_ready_i=1: 4 consecutive valid words and ready_o constantly 1. The result checks 1/cycle throughput.
- Assert rst_ni=0 while in OUT2: instr_valid_o drops immediately (async). After release, state is IDLE with ready_o=1, and no stale ADDI word is emitted.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs instruction fields and a two's-complement immediate into RV32I words,
// optionally splitting an out-of-range li into a LUI+ADDI pair.
module imm_encoder #(
    parameter int EXPAND_LI = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        last_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, OUT1, OUT2} state_t;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;

    state_t      state_q;
    logic [31:0] instr_q;
    logic        vld_q;
    logic        last_q;
    logic        err_q;
    logic [31:0] addi_q;

    logic signed [31:0] imm_s;
    logic [31:0] word_d;
    logic [31:0] addi_d;
    logic [31:0] li_sum;
    logic        legal;
    logic        is_li;
    logic        expand;
    logic        last_d;
    logic        err_d;
    logic        accept;
    logic        handshake;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    always_comb begin
        imm_s  = signed'(imm_i);
        legal  = 1'b0;
        word_d = '0;
        li_sum = imm_i + 32'h0000_0800;
        case (fmt_i)
            3'd0: begin
                legal  = in_range(imm_s, -32'sd2048, 32'sd2047);
                word_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            3'd1: begin
                legal  = in_range(imm_s, -32'sd2048, 32'sd2047);
                word_d = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            3'd2: begin
                legal  = in_range(imm_s, -32'sd4096, 32'sd4094) && !imm_i[0];
                word_d = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
            end
            3'd3: begin
                legal  = (imm_i[11:0] == 12'd0);
                word_d = {imm_i[31:12], rd_i, opcode_i};
            end
            3'd4: begin
                legal  = in_range(imm_s, -32'sd1048576, 32'sd1048574) && !imm_i[0];
                word_d = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            end
            default: begin
                legal  = 1'b0;
                word_d = '0;
            end
        endcase

        is_li  = (fmt_i == 3'd0) && (opcode_i == OP_IMM) && (funct3_i == 3'd0)
                 && (rs1_i == 5'd0) && (rd_i != 5'd0);
        expand = (EXPAND_LI != 0) && is_li && !legal;
        // hi is rounded so that adding the sign-extended lo restores imm exactly
        addi_d = {imm_i[11:0], rd_i, 3'd0, rd_i, OP_IMM};
        if (expand)
            word_d = {li_sum[31:12], rd_i, OP_LUI};
        else if (!legal)
            word_d = '0;
        last_d = !expand;
        err_d  = !legal && !expand;
    end

    assign handshake = vld_q & instr_ready_i;
    assign ready_o   = (state_q == IDLE) | (handshake & last_q);
    assign accept    = valid_i & ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            instr_q <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            addi_q  <= '0;
        end else if (accept) begin
            state_q <= OUT1;
            instr_q <= word_d;
            vld_q   <= 1'b1;
            last_q  <= last_d;
            err_q   <= err_d;
            addi_q  <= expand ? addi_d : 32'd0;
        end else if (handshake) begin
            if (last_q) begin
                state_q <= IDLE;
                instr_q <= '0;
                vld_q   <= 1'b0;
                last_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= OUT2;
                instr_q <= addi_q;
                last_q  <= 1'b1;
                err_q   <= 1'b0;
                addi_q  <= '0;
            end
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = vld_q;
    assign last_o        = last_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder; a second instance runs with EXPAND_LI=0.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  fmt_i = '0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [31:0] imm_i = '0;
    logic        instr_ready_i = 1'b1;

    logic        ready_o, instr_valid_o, last_o, err_o;
    logic [31:0] instr_o;
    logic        ready0, valid0, last0, err0;
    logic [31:0] instr0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imm_encoder #(.EXPAND_LI(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .instr_o(instr_o),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .last_o(last_o), .err_o(err_o)
    );

    imm_encoder #(.EXPAND_LI(0)) dut_noexp (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready0),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .instr_o(instr0),
        .instr_valid_o(valid0), .instr_ready_i(instr_ready_i),
        .last_o(last0), .err_o(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        fmt_i = f; opcode_i = op; funct3_i = f3; rd_i = rd;
        rs1_i = rs1; rs2_i = rs2; imm_i = imm; valid_i = 1'b1;
    endtask

    // Presents a request, waits (bounded) for acceptance, returns 1 ns after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        int n = 0;
        set_req(f, op, f3, rd, rs1, rs2, imm);
        #0;
        while (!ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic single(input string tag, input logic [2:0] f, input logic [6:0] op,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
        issue(f, op, f3, rd, rs1, rs2, imm);
        check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
        check({tag, "_instr"}, instr_o, exp_instr);
        check({tag, "_err"},   32'(err_o), 32'(exp_err));
        check({tag, "_last"},  32'(last_o), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [31:0] stream_exp [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_last",  32'(last_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        @(posedge clk); #3 rst_ni = 1'b1;
        @(posedge clk); #1;

        // ADDI x5,x0,-1 under back-pressure
        instr_ready_i = 1'b0;
        issue(3'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        check("addi_valid", 32'(instr_valid_o), 32'd1);
        check("addi_instr", instr_o, 32'hFFF0_0293);
        check("addi_last",  32'(last_o), 32'd1);
        check("addi_err",   32'(err_o), 32'd0);
        check("addi_bp_ready", 32'(ready_o), 32'd0);
        instr_ready_i = 1'b1; #1;
        check("addi_ready_comb", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        check("addi_drained", 32'(instr_valid_o), 32'd0);

        // li x5,0x12345678 with stalls between the two words
        instr_ready_i = 1'b0;
        issue(3'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        check("li_w1", instr_o, 32'h1234_52B7);
        check("li_w1_last", 32'(last_o), 32'd0);
        check("li_w1_err", 32'(err_o), 32'd0);
        check("noexp_li_err", 32'(err0), 32'd1);
        check("noexp_li_instr", instr0, 32'd0);
        check("noexp_li_last", 32'(last0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("li_hold_instr", instr_o, 32'h1234_52B7);
            check("li_hold_last", 32'(last_o), 32'd0);
            check("li_hold_ready", 32'(ready_o), 32'd0);
        end
        instr_ready_i = 1'b1; #1;
        check("li_w1_ready", 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        check("li_w2", instr_o, 32'h6782_8293);
        check("li_w2_valid", 32'(instr_valid_o), 32'd1);
        check("li_w2_last", 32'(last_o), 32'd1);
        check("li_w2_err", 32'(err_o), 32'd0);
        @(posedge clk); #1;
        check("li_drained", 32'(instr_valid_o), 32'd0);

        single("beq", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        single("jal", 3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        single("b_odd", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 32'd0, 1'b1);
        single("u_low", 3'd3, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1001, 32'd0, 1'b1);
        single("s_2048", 3'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'h0000_0800, 32'd0, 1'b1);
        single("fmt6", 3'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);

        // Back-to-back single-word stream
        for (int i = 0; i < 4; i++) begin
            set_req(3'd0, 7'h13, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
            #0;
            check("stream_ready", 32'(ready_o), 32'd1);
            @(posedge clk); #1;
            check("stream_valid", 32'(instr_valid_o), 32'd1);
            check("stream_instr", instr_o, stream_exp[i]);
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("stream_drained", 32'(instr_valid_o), 32'd0);

        // Async reset while the ADDI half is held
        issue(3'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        @(posedge clk); #1;
        check("rst2_in_out2", instr_o, 32'h6782_8293);
        instr_ready_i = 1'b0;
        rst_ni = 1'b0; #1;
        check("rst2_valid_drop", 32'(instr_valid_o), 32'd0);
        check("rst2_instr_clr", instr_o, 32'd0);
        #2 rst_ni = 1'b1;
        @(posedge clk); #1;
        check("rst2_ready", 32'(ready_o), 32'd1);
        instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst2_no_stale", 32'(instr_valid_o), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
